interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Arbitrates and sequences the 6502 interrupt, break and reset entry micro-sequence. It samples RESET, NMI, IRQ and BRK requests at instruction boundaries and drives a fixed multi-cycle sequence: dummy read, three stack pushes (PCH, PCL, P), then the two vector fetches. Along the way it strobes the processor status register: it supplies the pushed B bit and sets the I flag. It sits beside the instruction decoder and the processor status register, and owns all stack and vector control for interrupt entry.

## Interface
- No parameters; the vector addresses are fixed: NMI 16'hFFFA, RESET 16'hFFFC, IRQ/BRK 16'hFFFE.
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset. Clears the block to IDLE and sets the reset request.
- i_rdy  in  1  CPU ready; when low, all state holds.
- i_sync  in  1  instruction boundary (opcode fetch cycle of the next instruction).
- i_brk  in  1  BRK opcode decoded; qualified by i_sync.
- i_nmi_n  in  1  NMI pin, active-low, falling-edge sensitive.
- i_irq_n  in  1  IRQ pin, active-low, level sensitive.
- i_p_i  in  1  current I flag from the processor status register.
- o_busy  out  1  sequence in progress (state != IDLE).
- o_force_brk  out  1  force IR to 8'h00. Asserted in DUMMY for RESET, NMI and IRQ sequences.
- o_push_pch / o_push_pcl / o_push_p  out  1 each  stack-push cycle indicators.
- o_stack_we  out  1  stack write enable. Equals OR of the push indicators, but is 0 for RESET sequences (dummy stack reads).
- o_p_b  out  1  B bit value for the pushed P: 1 for BRK, 0 otherwise.
- o_set_i  out  1  one-cycle strobe to set the I flag.
- o_vec_fetch  out  1  vector fetch cycle.
- o_vec_addr  out  16  vector byte address; valid while o_vec_fetch = 1.
- o_done  out  1  one-cycle pulse on the final vector fetch.

## Operation
- States: IDLE, DUMMY, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- Outputs are Moore-decoded from the state and the latched source register `src` ∈ {RES, NMI, IRQ, BRK}.
- NMI edge detect:
  - Register the previous i_nmi_n.
  - prev = 1 and current = 0 sets nmi_pend.
  - nmi_pend clears on entering VEC_LO with src = NMI.
  - A new edge in the same cycle as the clear wins; nmi_pend stays set.
- res_pend is set by i_reset and cleared on leaving IDLE with src = RES.
- Start from IDLE when i_rdy = 1. Priority: RES > NMI > IRQ > BRK.
  - RES: res_pend. Starts without i_sync.
  - NMI: i_sync and nmi_pend.
  - IRQ: i_sync, i_irq_n = 0 and i_p_i = 0.
  - BRK: i_sync and i_brk.
  - On start: latch src, go to DUMMY.
- Transitions: DUMMY→PUSH_PCH→PUSH_PCL→PUSH_P→VEC_LO→VEC_HI→IDLE, one per cycle while i_rdy = 1.
- NMI hijack: if src ∈ {IRQ, BRK} and nmi_pend = 1 in PUSH_P, src becomes NMI on entering VEC_LO.
  - o_p_b keeps the original value; it is already pushed.
  - nmi_pend clears on that entry.
- o_set_i = 1 in VEC_LO for all sources.
- o_vec_addr:
  - VEC_LO: base(src).
  - VEC_HI: base(src) | 16'h0001.
  - All other states: 16'h0000.
- o_p_b is valid in PUSH_P and is 0 in all other states.
- IRQ is not latched. If it is released before i_sync, no sequence starts.

## Timing
- Reset values: state IDLE, src RES, res_pend 1, nmi_pend 0, prev-NMI 1. All outputs 0.
- Reset sequence: the first rising edge with i_reset low and i_rdy = 1 enters DUMMY. VEC_HI is reached 5 cycles later.
- Sequence length: 6 cycles (DUMMY..VEC_HI) after the start edge. The next IDLE start is possible on the edge after VEC_HI.
- i_rdy low: state, src and pend flags hold. nmi_pend can still be set. Outputs hold their current decoded values.
- i_reset asserted mid-sequence aborts immediately, asynchronously, to reset values.
- NMI edge latency: an edge on i_nmi_n sampled at edge k gives nmi_pend = 1 after edge k+1.

## Test plan
- Reset release, i_rdy = 1 → DUMMY with o_force_brk = 1. Three push cycles with o_stack_we = 0. VEC_LO o_vec_addr = FFFC with o_set_i = 1. VEC_HI o_vec_addr = FFFD with o_done = 1. Then IDLE.
- BRK at i_sync, I = 0 → o_force_brk = 0, o_stack_we = 1 for 3 cycles, o_p_b = 1 in PUSH_P, vectors FFFE/FFFF.
- i_irq_n = 0 with i_p_i = 1 at i_sync → stays IDLE. With i_p_i = 0 → sequence runs, o_p_b = 0, vectors FFFE/FFFF.
- IRQ and NMI both pending at i_sync → NMI wins, vectors FFFA/FFFB. IRQ (still held) starts on the next i_sync after return.
- NMI falling edge during an IRQ sequence, latched by PUSH_P → VEC_LO = FFFA, o_p_b = 0, nmi_pend cleared. No second NMI sequence follows.
- i_rdy low for 3 cycles in PUSH_PCL → outputs hold; total sequence is 9 cycles. Then i_reset high in PUSH_P → all outputs 0 immediately, and the reset sequence runs after release.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Purpose : 6502 interrupt/BRK/reset entry sequencer; arbitrates RES > NMI > IRQ > BRK and drives dummy, 3 pushes, 2 vector fetches.
// Latency : a request seen at the start edge gives DUMMY on the next cycle; VEC_HI follows 5 cycles later (6-cycle sequence).
// Backpressure: i_rdy low freezes state, source and pending flags; NMI edges are still captured; outputs hold their decoded values.
module interrupt_sequencer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rdy,
    input  logic        i_sync,
    input  logic        i_brk,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_p_i,
    output logic        o_busy,
    output logic        o_force_brk,
    output logic        o_push_pch,
    output logic        o_push_pcl,
    output logic        o_push_p,
    output logic        o_stack_we,
    output logic        o_p_b,
    output logic        o_set_i,
    output logic        o_vec_fetch,
    output logic [15:0] o_vec_addr,
    output logic        o_done
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DUMMY    = 3'd1,
        ST_PUSH_PCH = 3'd2,
        ST_PUSH_PCL = 3'd3,
        ST_PUSH_P   = 3'd4,
        ST_VEC_LO   = 3'd5,
        ST_VEC_HI   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    state_t state_q, state_d;
    src_t   src_q, src_d;
    logic   res_pend_q, res_pend_d;
    logic   nmi_pend_q, nmi_pend_d;
    logic   nmi_cur_q, nmi_cur_d;
    logic   nmi_prev_q, nmi_prev_d;
    logic   nmi_edge;
    logic   nmi_clr;
    logic   irq_req;

    // Vector base for the latched source; BRK shares the IRQ vector.
    function automatic logic [15:0] vec_base(input src_t s);
        case (s)
            SRC_NMI: vec_base = VEC_NMI;
            SRC_RES: vec_base = VEC_RES;
            default: vec_base = VEC_IRQ;
        endcase
    endfunction

    // State, source, pending flags and NMI pin history; reset re-arms the reset request.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_RES;
            res_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_cur_q  <= 1'b1;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            res_pend_q <= res_pend_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_cur_q  <= nmi_cur_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    // NMI pin is sampled every cycle regardless of i_rdy so a falling edge is never lost;
    // the edge is detected between two registered samples, one cycle after the pin is sampled low.
    always_comb begin
        nmi_cur_d  = i_nmi_n;
        nmi_prev_d = nmi_cur_q;
        nmi_edge   = nmi_prev_q & ~nmi_cur_q;
        irq_req    = ~i_irq_n & ~i_p_i;
    end

    // Next-state logic: arbitration in IDLE, fixed walk through the sequence, NMI hijack at PUSH_P.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        res_pend_d = res_pend_q;
        nmi_clr    = 1'b0;
        if (i_rdy) begin
            case (state_q)
                ST_IDLE: begin
                    if (res_pend_q) begin
                        state_d    = ST_DUMMY;
                        src_d      = SRC_RES;
                        res_pend_d = 1'b0;
                    end else if (i_sync && nmi_pend_q) begin
                        state_d = ST_DUMMY;
                        src_d   = SRC_NMI;
                    end else if (i_sync && irq_req) begin
                        state_d = ST_DUMMY;
                        src_d   = SRC_IRQ;
                    end else if (i_sync && i_brk) begin
                        state_d = ST_DUMMY;
                        src_d   = SRC_BRK;
                    end
                end
                ST_DUMMY:    state_d = ST_PUSH_PCH;
                ST_PUSH_PCH: state_d = ST_PUSH_PCL;
                ST_PUSH_PCL: state_d = ST_PUSH_P;
                ST_PUSH_P: begin
                    state_d = ST_VEC_LO;
                    // A late NMI steals the vector; the already-pushed B bit is unaffected.
                    if ((src_q == SRC_IRQ || src_q == SRC_BRK) && nmi_pend_q) begin
                        src_d = SRC_NMI;
                    end
                    // Entering the NMI vector fetch consumes the pending NMI.
                    if (src_d == SRC_NMI) begin
                        nmi_clr = 1'b1;
                    end
                end
                ST_VEC_LO:   state_d = ST_VEC_HI;
                ST_VEC_HI:   state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
        // A fresh edge arriving with the clear keeps the request alive.
        nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);
    end

    // Moore output decode from state and latched source.
    always_comb begin
        o_busy      = 1'b0;
        o_force_brk = 1'b0;
        o_push_pch  = 1'b0;
        o_push_pcl  = 1'b0;
        o_push_p    = 1'b0;
        o_stack_we  = 1'b0;
        o_p_b       = 1'b0;
        o_set_i     = 1'b0;
        o_vec_fetch = 1'b0;
        o_vec_addr  = 16'h0000;
        o_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
            end
            ST_DUMMY: begin
                o_busy      = 1'b1;
                o_force_brk = (src_q != SRC_BRK);
            end
            ST_PUSH_PCH: begin
                o_busy     = 1'b1;
                o_push_pch = 1'b1;
                o_stack_we = (src_q != SRC_RES);
            end
            ST_PUSH_PCL: begin
                o_busy     = 1'b1;
                o_push_pcl = 1'b1;
                o_stack_we = (src_q != SRC_RES);
            end
            ST_PUSH_P: begin
                o_busy     = 1'b1;
                o_push_p   = 1'b1;
                o_stack_we = (src_q != SRC_RES);
                o_p_b      = (src_q == SRC_BRK);
            end
            ST_VEC_LO: begin
                o_busy      = 1'b1;
                o_set_i     = 1'b1;
                o_vec_fetch = 1'b1;
                o_vec_addr  = vec_base(src_q);
            end
            ST_VEC_HI: begin
                o_busy      = 1'b1;
                o_vec_fetch = 1'b1;
                o_vec_addr  = vec_base(src_q) | 16'h0001;
                o_done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Purpose : directed bench for interrupt_sequencer with hand-computed per-cycle expectations.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: exercises i_rdy stalls and asynchronous reset abort.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst, rdy, sync, brk, nmi_n, irq_n, p_i;
    logic        busy, force_brk, push_pch, push_pcl, push_p, stack_we, p_b, set_i, vec_fetch, done;
    logic [15:0] vec_addr;
    logic [9:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rdy       (rdy),
        .i_sync      (sync),
        .i_brk       (brk),
        .i_nmi_n     (nmi_n),
        .i_irq_n     (irq_n),
        .i_p_i       (p_i),
        .o_busy      (busy),
        .o_force_brk (force_brk),
        .o_push_pch  (push_pch),
        .o_push_pcl  (push_pcl),
        .o_push_p    (push_p),
        .o_stack_we  (stack_we),
        .o_p_b       (p_b),
        .o_set_i     (set_i),
        .o_vec_fetch (vec_fetch),
        .o_vec_addr  (vec_addr),
        .o_done      (done)
    );

    // {busy, force_brk, push_pch, push_pcl, push_p, stack_we, p_b, set_i, vec_fetch, done}
    assign flags = {busy, force_brk, push_pch, push_pcl, push_p, stack_we, p_b, set_i, vec_fetch, done};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s : got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [9:0] exp_flags, input logic [15:0] exp_addr);
        chk({tag, ".flags"}, {6'd0, flags}, {6'd0, exp_flags});
        chk({tag, ".addr"}, vec_addr, exp_addr);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected flags per sequence cycle: 0 DUMMY, 1 PCH, 2 PCL, 3 P, 4 VEC_LO, 5 VEC_HI.
    function automatic logic [9:0] fl(input int cyc, input bit res, input bit is_brk);
        case (cyc)
            0:       fl = {1'b1, ~is_brk, 8'b0000_0000};
            1:       fl = {3'b101, 2'b00, ~res, 4'b0000};
            2:       fl = {3'b100, 2'b10, ~res, 4'b0000};
            3:       fl = {3'b100, 2'b01, ~res, is_brk, 3'b000};
            4:       fl = 10'b10_0000_0110;
            5:       fl = 10'b10_0000_0011;
            default: fl = 10'b0;
        endcase
    endfunction

    // Called one unit after the start edge (DUMMY); walks to the IDLE cycle after VEC_HI.
    task automatic expect_seq(input string tag, input bit res, input bit is_brk, input logic [15:0] base);
        for (int c = 0; c < 6; c++) begin
            chk_cyc($sformatf("%s.c%0d", tag, c), fl(c, res, is_brk),
                    (c == 4) ? base : (c == 5) ? (base | 16'h0001) : 16'h0000);
            step();
        end
        chk_cyc({tag, ".idle"}, 10'b0, 16'h0000);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; sync = 1'b0; brk = 1'b0;
        nmi_n = 1'b1; irq_n = 1'b1; p_i = 1'b0;

        // Reset state, then the reset sequence with dummy stack reads.
        #1;
        chk_cyc("rst_hold", 10'b0, 16'h0000);
        step();
        chk_cyc("rst_hold2", 10'b0, 16'h0000);
        rst = 1'b0;
        step();
        expect_seq("res", 1'b1, 1'b0, 16'hFFFC);
        step();
        chk_cyc("res_once", 10'b0, 16'h0000);

        // BRK at instruction boundary.
        sync = 1'b1; brk = 1'b1;
        step();
        sync = 1'b0; brk = 1'b0;
        expect_seq("brk", 1'b0, 1'b1, 16'hFFFE);

        // IRQ masked by I, then unmasked.
        irq_n = 1'b0; p_i = 1'b1; sync = 1'b1;
        step();
        chk_cyc("irq_masked1", 10'b0, 16'h0000);
        step();
        chk_cyc("irq_masked2", 10'b0, 16'h0000);
        p_i = 1'b0;
        step();
        sync = 1'b0; irq_n = 1'b1;
        expect_seq("irq", 1'b0, 1'b0, 16'hFFFE);

        // NMI and IRQ both pending: NMI first, held IRQ afterwards.
        irq_n = 1'b0; nmi_n = 1'b0;
        step();
        chk_cyc("nmi_wait1", 10'b0, 16'h0000);
        step();
        chk_cyc("nmi_wait2", 10'b0, 16'h0000);
        sync = 1'b1;
        step();
        sync = 1'b0; nmi_n = 1'b1;
        expect_seq("nmi_first", 1'b0, 1'b0, 16'hFFFA);
        sync = 1'b1;
        step();
        sync = 1'b0; irq_n = 1'b1;
        expect_seq("irq_after", 1'b0, 1'b0, 16'hFFFE);

        // NMI arriving during an IRQ sequence hijacks the vector; B stays 0.
        irq_n = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0; irq_n = 1'b1; nmi_n = 1'b0;
        expect_seq("hijack", 1'b0, 1'b0, 16'hFFFA);
        sync = 1'b1;
        step();
        chk_cyc("no_2nd_nmi", 10'b0, 16'h0000);
        sync = 1'b0; nmi_n = 1'b1;
        step();

        // i_rdy stall in PUSH_PCL: outputs hold, 9-cycle sequence.
        sync = 1'b1; brk = 1'b1;
        step();
        sync = 1'b0; brk = 1'b0;
        chk_cyc("stall.dummy", fl(0, 1'b0, 1'b1), 16'h0000);
        step();
        chk_cyc("stall.pch", fl(1, 1'b0, 1'b1), 16'h0000);
        step();
        chk_cyc("stall.pcl", fl(2, 1'b0, 1'b1), 16'h0000);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cyc($sformatf("stall.hold%0d", i), fl(2, 1'b0, 1'b1), 16'h0000);
        end
        rdy = 1'b1;
        step();
        chk_cyc("stall.p", fl(3, 1'b0, 1'b1), 16'h0000);
        step();
        chk_cyc("stall.vlo", fl(4, 1'b0, 1'b1), 16'hFFFE);
        step();
        chk_cyc("stall.vhi", fl(5, 1'b0, 1'b1), 16'hFFFF);
        step();
        chk_cyc("stall.idle", 10'b0, 16'h0000);

        // Asynchronous reset in PUSH_P aborts at once; reset sequence follows release.
        sync = 1'b1; brk = 1'b1;
        step();
        sync = 1'b0; brk = 1'b0;
        step();
        step();
        step();
        chk_cyc("abort.p", fl(3, 1'b0, 1'b1), 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        chk_cyc("abort.async", 10'b0, 16'h0000);
        step();
        chk_cyc("abort.held", 10'b0, 16'h0000);
        rst = 1'b0;
        step();
        expect_seq("res2", 1'b1, 1'b0, 16'hFFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
